// File: rtl/j_u2txseq_if.sv
// Host-side bus of the UART2 transmit sequencer: holding-register writes,
// status read strobe and the status/interrupt flags returned to the host.
interface j_u2txseq_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] din;
  logic                 txdw;
  logic                 stat_rd;
  logic                 thre;
  logic                 tsre;
  logic                 tx_busy;
  logic                 tx_int;
  logic                 tx_ovr;

  modport master (
    output din, txdw, stat_rd,
    input  thre, tsre, tx_busy, tx_int, tx_ovr
  );

  modport slave (
    input  din, txdw, stat_rd,
    output thre, tsre, tx_busy, tx_int, tx_ovr
  );
endinterface

// File: rtl/j_u2txseq.sv
// UART2 transmit sequencer: frames bytes from a double-buffered holding register
// onto txd at 16 bx16 ticks per bit (start, data LSB first, optional parity, stop).
module j_u2txseq #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic           sys_clk,
  input  logic           reset,
  input  logic           bx16,
  input  logic           par_en,
  input  logic           par_odd,
  input  logic           brk,
  output logic           txd,
  j_u2txseq_if.slave     bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t               state;
  state_t               state_nxt;
  logic [3:0]           tick_cnt;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] shift;
  logic                 thre_q;
  logic                 tx_int_q;
  logic                 tx_ovr_q;
  logic                 frame_par_en;
  logic                 frame_par;
  logic                 line;
  logic                 bit_end;
  logic                 last_stop;
  logic                 transfer;

  assign bit_end   = (state != IDLE) && bx16 && (tick_cnt == 4'd15);
  assign last_stop = (state == STOP) && bit_end && (stop_idx == LAST_STOP);
  assign transfer  = !thre_q && ((state == IDLE) || last_stop);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (transfer) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && (bit_idx == LAST_BIT))
                 state_nxt = frame_par_en ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (last_stop) state_nxt = transfer ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Parity is fixed at transfer time so mid-frame par_en/par_odd changes are ignored.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      tick_cnt     <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      hold         <= '0;
      shift        <= '0;
      thre_q       <= 1'b1;
      tx_int_q     <= 1'b0;
      tx_ovr_q     <= 1'b0;
      frame_par_en <= 1'b0;
      frame_par    <= 1'b0;
    end else begin
      tx_int_q <= transfer;

      if ((state == IDLE) || transfer) tick_cnt <= '0;
      else if (bx16)                   tick_cnt <= tick_cnt + 4'd1;

      if ((state == DATA) && bit_end)
        bit_idx <= (bit_idx == LAST_BIT) ? 3'd0 : bit_idx + 3'd1;

      if ((state == STOP) && bit_end)
        stop_idx <= last_stop ? 1'b0 : stop_idx + 1'b1;

      if (transfer) begin
        shift        <= hold;
        frame_par_en <= par_en;
        frame_par    <= (^hold) ^ par_odd;
      end else if ((state == DATA) && bit_end) begin
        shift <= shift >> 1;
      end

      if (bus.txdw)     hold <= bus.din;

      if (bus.txdw)     thre_q <= 1'b0;
      else if (transfer) thre_q <= 1'b1;

      if (bus.txdw && !thre_q && !transfer) tx_ovr_q <= 1'b1;
      else if (bus.stat_rd)                 tx_ovr_q <= 1'b0;
    end
  end

  always_comb begin
    line = 1'b1;
    case (state)
      START:   line = 1'b0;
      DATA:    line = shift[0];
      PARITY:  line = frame_par;
      default: line = 1'b1;
    endcase
  end

  assign txd         = brk ? 1'b0 : line;
  assign bus.thre    = thre_q;
  assign bus.tsre    = (state == IDLE);
  assign bus.tx_busy = (state != IDLE);
  assign bus.tx_int  = tx_int_q;
  assign bus.tx_ovr  = tx_ovr_q;

endmodule
